// File: rtl/handshake_rr_mux_pkg.sv
// Shared constants and width helpers for the round-robin handshake multiplexer.
// Every file of the mux imports this package.
package handshake_rr_mux_pkg;

    localparam int unsigned GapStream = 0;
    localparam int unsigned GapPulse  = 1;

    localparam int unsigned NDefault = 4;

    function automatic int unsigned chan_width(int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int unsigned cnt_width(int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    localparam int unsigned CHW = chan_width(NDefault);

endpackage

// File: rtl/hs_chan_fifo.sv
// Per-channel FIFO. Push and pop are synchronous. The head word is always
// visible on rdata. A push while full, or a pop while empty, is ignored.
module hs_chan_fifo
    import handshake_rr_mux_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          push,
    input  logic [WIDTH-1:0]              wdata,
    input  logic                          pop,
    output logic [WIDTH-1:0]              rdata,
    output logic [cnt_width(DEPTH)-1:0]   count,
    output logic                          empty,
    output logic                          full
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = cnt_width(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wptr_q, rptr_q;
    logic [CW-1:0]    count_q, count_d;
    logic             wr_en, rd_en;

    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));
    assign count = count_q;
    assign rdata = mem_q[rptr_q];

    assign wr_en = push && !full;
    assign rd_en = pop && !empty;

    always_comb begin
        count_d = count_q;
        unique case ({wr_en, rd_en})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            count_q <= count_d;
            // DEPTH is a power of two, so the pointers wrap on overflow.
            if (wr_en) wptr_q <= wptr_q + PW'(1);
            if (rd_en) rptr_q <= rptr_q + PW'(1);
        end
    end

    // Storage needs no reset: count and pointers decide what is valid.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wptr_q] <= wdata;
    end

endmodule

// File: rtl/handshake_rr_mux.sv
// Buffers N source channels in small FIFOs and drains them round-robin into one
// registered output port that pulses dvalid once per word, with dbusy back-pressure.
module handshake_rr_mux
    import handshake_rr_mux_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned N     = 4,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned GAP   = GapStream
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [N-1:0]               sready,
    input  logic [N*WIDTH-1:0]         din,
    output logic [N-1:0]               sidle,
    output logic [N-1:0]               sfull,
    output logic [N-1:0]               sdrop,
    input  logic                       dbusy,
    output logic                       dvalid,
    output logic [WIDTH-1:0]           dout,
    output logic [chan_width(N)-1:0]   dchan
);

    localparam int unsigned CHW = chan_width(N);
    localparam int unsigned CW  = cnt_width(DEPTH);
    localparam logic [CHW-1:0] LastChan = CHW'(N - 1);

    logic [N-1:0]     push, pop, empty, full, avail;
    logic [WIDTH-1:0] head  [N];
    logic [CW-1:0]    count [N];

    for (genvar i = 0; i < N; i++) begin : g_chan
        hs_chan_fifo #(
            .WIDTH (WIDTH),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk   (clk),
            .rst_n (rst_n),
            .push  (push[i]),
            .wdata (din[i*WIDTH +: WIDTH]),
            .pop   (pop[i]),
            .rdata (head[i]),
            .count (count[i]),
            .empty (empty[i]),
            .full  (full[i])
        );
        assign avail[i] = (count[i] != '0);
    end

    // Fullness uses the pre-edge count, so a same-cycle pop never makes room.
    assign push  = sready & ~full;
    assign sidle = empty;
    assign sfull = full;

    logic             dvalid_q, dvalid_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic [CHW-1:0]   dchan_q, dchan_d;
    logic [CHW-1:0]   ptr_q, ptr_d;
    logic [N-1:0]     sdrop_q, sdrop_d;
    logic             pop_en, found, grant;
    logic [CHW-1:0]   winner, cand;

    always_comb begin
        pop_en = !dbusy && !((GAP != 0) && dvalid_q);
        found  = 1'b0;
        winner = '0;
        cand   = '0;
        // Search starts just after the last winner and wraps modulo N.
        for (int unsigned k = 1; k <= N; k++) begin
            cand = CHW'((32'(ptr_q) + k) % N);
            if (!found && avail[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
        grant = found && pop_en;

        pop = '0;
        if (grant) pop[winner] = 1'b1;

        ptr_d    = grant ? winner : ptr_q;
        dvalid_d = grant;
        dout_d   = grant ? head[winner] : '0;
        dchan_d  = grant ? winner : '0;
        sdrop_d  = sready & full;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q    <= LastChan;
            dvalid_q <= 1'b0;
            dout_q   <= '0;
            dchan_q  <= '0;
            sdrop_q  <= '0;
        end else begin
            ptr_q    <= ptr_d;
            dvalid_q <= dvalid_d;
            dout_q   <= dout_d;
            dchan_q  <= dchan_d;
            sdrop_q  <= sdrop_d;
        end
    end

    assign dvalid = dvalid_q;
    assign dout   = dout_q;
    assign dchan  = dchan_q;
    assign sdrop  = sdrop_q;

endmodule
